// File: rtl/rv_muldiv.sv
// RV32M multiply/divide: radix-2 shift-add multiply, restoring divide, DATA_W+1 cycles (fast path 1); start ignored while busy.
// Define RV_MULDIV_DIV_EN to build the divider; otherwise ops 100-111 finish in one cycle with result 0.
module rv_muldiv #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [2:0]          op_q;
    logic                neg_q;
    logic [DATA_W-1:0]   m_q;
    logic [DATA_W-1:0]   hi_q;
    logic [DATA_W-1:0]   lo_q;
    logic [DATA_W-1:0]   result_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                busy_q;
    logic                done_q;

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

    logic              is_div;
    logic              signed_a;
    logic              signed_b;
    logic              a_neg;
    logic              b_neg;
    logic              take_fast;
    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] b_mag;
    logic [DATA_W-1:0] fast_res;
`ifdef RV_MULDIV_DIV_EN
    logic              b_zero;
    logic              ovf;
`endif

    always_comb begin
        is_div   = op[2];
        signed_a = is_div ? ~op[0] : (op[1:0] != 2'b11);
        signed_b = is_div ? ~op[0] : ~op[1];
        a_neg    = signed_a & a[DATA_W-1];
        b_neg    = signed_b & b[DATA_W-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
`ifdef RV_MULDIV_DIV_EN
        b_zero    = (b == '0);
        // Only DIV/REM (op[0]=0) can overflow: most-negative / -1.
        ovf       = ~op[0] & (a == {1'b1, {(DATA_W-1){1'b0}}}) & (&b);
        take_fast = is_div & (b_zero | ovf);
        if (b_zero) begin
            fast_res = op[1] ? a : '1;
        end else begin
            fast_res = op[1] ? '0 : a;
        end
`else
        take_fast = is_div;
        fast_res  = '0;
`endif
    end

    logic [DATA_W:0]     mul_sum;
    logic [DATA_W-1:0]   hi_d;
    logic [DATA_W-1:0]   lo_d;
    logic [DATA_W-1:0]   fin_res;
    logic [2*DATA_W-1:0] prod;
    logic [2*DATA_W-1:0] prod_s;
`ifdef RV_MULDIV_DIV_EN
    logic [DATA_W:0]     rem_sh;
    logic [DATA_W:0]     diff;
`endif

    always_comb begin
        // hi:lo shifts right; multiplier bits consumed from lo[0].
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        hi_d    = mul_sum[DATA_W:1];
        lo_d    = {mul_sum[0], lo_q[DATA_W-1:1]};
`ifdef RV_MULDIV_DIV_EN
        rem_sh = {hi_q, lo_q[DATA_W-1]};
        diff   = rem_sh - {1'b0, m_q};
        if (op_q[2]) begin
            hi_d = diff[DATA_W] ? rem_sh[DATA_W-1:0] : diff[DATA_W-1:0];
            lo_d = {lo_q[DATA_W-2:0], ~diff[DATA_W]};
        end
`endif
        prod    = {hi_d, lo_d};
        prod_s  = neg_q ? -prod : prod;
        fin_res = (op_q[1:0] == 2'b00) ? prod_s[DATA_W-1:0] : prod_s[2*DATA_W-1:DATA_W];
`ifdef RV_MULDIV_DIV_EN
        if (op_q[2]) begin
            fin_res = op_q[1] ? (neg_q ? -hi_d : hi_d) : (neg_q ? -lo_d : lo_d);
        end
`else
        if (op_q[2]) begin
            fin_res = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            neg_q    <= 1'b0;
            m_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (flush) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_CALC: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_q  <= S_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= fin_res;
                    end
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                    if (start) begin
                        op_q  <= op;
                        // REM takes the dividend sign; everything else the xor.
                        neg_q <= (is_div & op[1]) ? a_neg : (a_neg ^ b_neg);
                        m_q   <= is_div ? b_mag : a_mag;
                        lo_q  <= is_div ? a_mag : b_mag;
                        hi_q  <= '0;
                        cnt_q <= '0;
                        if (take_fast) begin
                            state_q  <= S_DONE;
                            done_q   <= 1'b1;
                            result_q <= fast_res;
                        end else begin
                            state_q <= S_CALC;
                            busy_q  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv_muldiv.sv
// Bench for rv_muldiv: directed vector table, hand-written flush/reset/back-to-back sequences, randomized ops vs arithmetic model.
module tb_rv_muldiv;
    localparam int W = 32;

    logic          clk;
    logic          reset;
    logic          start;
    logic          flush;
    logic [2:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;

    int n_cmp  = 0;
    int n_fail = 0;

    rv_muldiv #(.DATA_W(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .result(result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                    input logic [31:0] r, input int l);
        vec_t v;
        v.op = o; v.a = x; v.b = y; v.exp_res = r; v.exp_lat = l;
        vecs.push_back(v);
    endfunction

    function automatic logic [31:0] model_res(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx;
        longint      sy;
        logic [63:0] ux;
        logic [63:0] uy;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        p  = '0;
        case (o)
            3'b000: begin p = ux * uy;           return p[31:0];  end
            3'b001: begin p = sx * sy;           return p[63:32]; end
            3'b010: begin p = sx * longint'(uy); return p[63:32]; end
            3'b011: begin p = ux * uy;           return p[63:32]; end
            default: begin
`ifdef RV_MULDIV_DIV_EN
                if (y == 0) return o[1] ? x : 32'hFFFF_FFFF;
                if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'h0 : x;
                case (o[1:0])
                    2'b00:   p = sx / sy;
                    2'b01:   p = ux / uy;
                    2'b10:   p = sx % sy;
                    default: p = ux % uy;
                endcase
                return p[31:0];
`else
                return 32'h0;
`endif
            end
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        int l;
        l = W + 1;
        if (o[2]) begin
`ifdef RV_MULDIV_DIV_EN
            if (y == 0 || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) l = 1;
`else
            l = 1;
`endif
        end
        return l;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Called at a negedge; returns at the cycle-1 sample point.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns at the negedge of the done cycle (or after the cycle budget with lat=0).
    task automatic wait_done(output logic [31:0] res, output int lat, output int bcnt);
        res = '0; lat = 0; bcnt = 0;
        for (int c = 1; c <= 100; c++) begin
            if (busy) bcnt++;
            if (done) begin
                lat = c;
                res = result;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_check(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                             input logic [31:0] er, input int el);
        logic [31:0] r;
        int          l;
        int          bc;
        issue(o, x, y);
        wait_done(r, l, bc);
        check({tag, "_res"}, 64'(r), 64'(er));
        check({tag, "_lat"}, 64'(l), 64'(el));
        check({tag, "_busy"}, 64'(bc), 64'(el - 1));
    endtask

    logic [31:0] last_exp;
    logic [31:0] r;
    int          l;
    int          bc;
    int          dcnt;
    logic [2:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;

    initial begin
        reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        add_vec(3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        add_vec(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        add_vec(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        add_vec(3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33);
        add_vec(3'b000, 32'd6,         32'd7,         32'd42,        33);
`ifdef RV_MULDIV_DIV_EN
        add_vec(3'b100, 32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFA, 33);
        add_vec(3'b110, 32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFE, 33);
        add_vec(3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        add_vec(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1);
        add_vec(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
`else
        add_vec(3'b100, 32'd100,       32'd7,         32'h0,         1);
        add_vec(3'b101, 32'd5,         32'd0,         32'h0,         1);
        add_vec(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].exp_lat);
            @(negedge clk);
            check($sformatf("vec%0d_pulse", i), 64'(done), 64'd0);
            check($sformatf("vec%0d_idle", i), 64'(busy), 64'd0);
            check($sformatf("vec%0d_hold", i), 64'(result), 64'(vecs[i].exp_res));
        end

        // Back-to-back: second start issued in the DONE cycle.
`ifdef RV_MULDIV_DIV_EN
        run_check("b2b_first", 3'b100, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 33);
        run_check("b2b_second", 3'b110, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 33);
        last_exp = 32'hFFFF_FFFE;
`else
        run_check("b2b_first", 3'b000, 32'd6, 32'd7, 32'd42, 33);
        run_check("b2b_second", 3'b011, 32'hFFFF_FFFF, 32'd2, 32'd1, 33);
        last_exp = 32'd1;
`endif
        @(negedge clk);

        // Flush at cycle 10 of a MUL, with an ignored start at cycle 5.
        issue(3'b000, 32'd3, 32'd5);
        bc = 0;
        for (int c = 1; c <= 10; c++) begin
            if (c == 5) begin start = 1'b1; op = 3'b011; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; end
            if (c == 6) start = 1'b0;
            if (c == 10) flush = 1'b1;
            if (busy) bc++;
            @(negedge clk);
        end
        flush = 1'b0;
        check("flush_busy_before", 64'(bc), 64'd10);
        check("flush_busy_after", 64'(busy), 64'd0);
        check("flush_done", 64'(done), 64'd0);
        check("flush_result", 64'(result), 64'(last_exp));
        dcnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (done || busy) dcnt++;
            @(negedge clk);
        end
        check("flush_quiet", 64'(dcnt), 64'd0);

        // Flush and start together in IDLE: flush wins.
        op = 3'b000; a = 32'd9; b = 32'd9; start = 1'b1; flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", 64'(busy), 64'd0);
        check("flush_start_done", 64'(done), 64'd0);
        check("flush_start_result", 64'(result), 64'(last_exp));

        // Reset at cycle 20 of a MUL.
        issue(3'b000, 32'd6, 32'd7);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_done", 64'(done), 64'd0);
        check("rst_mid_result", 64'(result), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 150; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin ra = 32'($urandom_range(0, 300)) - 32'd150; rb = 32'($urandom_range(0, 20)) - 32'd10; end
                3: rb = 32'h1;
                default: ;
            endcase
            issue(ro, ra, rb);
            wait_done(r, l, bc);
            check($sformatf("rand%0d_res op=%0d a=%0h b=%0h", i, ro, ra, rb), 64'(r), 64'(model_res(ro, ra, rb)));
            check($sformatf("rand%0d_lat op=%0d", i, ro), 64'(l), 64'(model_lat(ro, ra, rb)));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_muldiv.md
RV_MULDIV -- requirements
Module: rv_muldiv

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width; legal values 8..64, even.
REQ-002 SHALL have parameter CNT_W, default $clog2(DATA_W)+1, iteration counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request; sampled only when busy=0.
REQ-006 SHALL have port op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have port a  input  DATA_W  rs1 operand (multiplicand/dividend).
REQ-008 SHALL have port b  input  DATA_W  rs2 operand (multiplier/divisor).
REQ-009 SHALL have port flush  input  1  abort in-flight op (pipeline kill).
REQ-010 SHALL have port busy  output  1  high while iterating; start ignored.
REQ-011 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-012 SHALL have port result  output  DATA_W  final value; held from done until next accepted start.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE.
REQ-014 IDLE or DONE with start=1 and flush=0 SHALL latch op/a/b; next state is CALC, or DONE for the fast path (REQ-019).
REQ-015 CALC SHALL perform one iteration per cycle for exactly DATA_W cycles, then enter DONE.
REQ-016 Latency: start sampled at edge 0 -> busy=1 in cycles 1..DATA_W, done=1 in cycle DATA_W+1, busy=0 in DONE.
REQ-017 Multiply SHALL be radix-2 shift-add on magnitudes into a 2*DATA_W product, sign-corrected per op; MUL returns low half, MULH/MULHSU/MULHU return high half.
REQ-018 Divide SHALL be restoring on magnitudes; quotient sign = sign(a) xor sign(b), remainder sign = sign(a) (signed ops only).
REQ-019 Fast path, done in cycle 1: divisor zero -> DIV/DIVU result all-ones, REM/REMU result a; signed overflow (a = most-negative, b = -1) -> DIV result a, REM result 0.
REQ-020 start while busy=1 SHALL be ignored, no state change.
REQ-021 start in the DONE cycle SHALL be accepted (back-to-back ops, no idle bubble).
REQ-022 flush SHALL force IDLE at the next edge from any state, suppress done, keep result unchanged; flush with start in the same cycle: flush wins, start dropped.
REQ-023 DONE SHALL last one cycle, then IDLE unless a new start is accepted.

Reset
REQ-024 reset=1 at an edge SHALL force IDLE, busy=0, done=0, result=0, counter=0, in any state including mid-CALC.
REQ-025 reset SHALL take priority over start and flush.

Configuration
REQ-026 Macro RV_MULDIV_DIV_EN defined: full behaviour above.
REQ-027 Macro RV_MULDIV_DIV_EN undefined: divider datapath SHALL not be synthesised; ops 100-111 complete via the fast path, done in cycle 1, result 0; multiply ops unchanged.

Verification (DATA_W=32)
REQ-028 MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, done in cycle 33, busy high in cycles 1-32.
REQ-029 MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
REQ-030 DIV a=0xFFFFFFEC (-20), b=3 -> 0xFFFFFFFA; REM same -> 0xFFFFFFFE; start issued in the DONE cycle accepted back-to-back.
REQ-031 DIVU a=5, b=0 -> 0xFFFFFFFF, done in cycle 1; REM a=0x80000000, b=0xFFFFFFFF -> 0, done in cycle 1.
REQ-032 flush at cycle 10 of a MUL -> no done, busy=0 in cycle 11, result unchanged; start at cycle 5 ignored; reset at cycle 20 -> all outputs 0 next cycle.
REQ-033 RV_MULDIV_DIV_EN undefined: DIV a=100, b=7 -> result 0, done in cycle 1; MUL 6*7 -> 42 in cycle 33.
